bus_memory_ws: RTL and testbench

Parametrised wait-state memory slave for the CPU data/instruction bus. It accepts one request at a time on the DV/bhw/write_notread bus. After a configurable number of wait cycles it returns a one-cycle DV response carrying sign- or zero-extended read data, or a write acknowledge. It is the successor to the fixed-latency bus memory in the CPU bench and FPGA top, and adds configurable depth, base address, latency, byte-lane handling and fault reporting.

---
 rtl/bus_mem_pkg.sv | 22 ++
 rtl/bus_lane_align.sv | 52 +++++
 rtl/bus_memory_ws.sv | 126 ++++++++++++
 tb/tb_bus_memory_ws.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_pkg.sv
// Shared definitions for the wait-state bus memory: bus size codes, FSM states and counter width.
package bus_mem_pkg;

    localparam int LAT_W = 4;

    localparam logic [2:0] BHW_B  = 3'b000;
    localparam logic [2:0] BHW_H  = 3'b001;
    localparam logic [2:0] BHW_W  = 3'b010;
    localparam logic [2:0] BHW_BU = 3'b100;
    localparam logic [2:0] BHW_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic bhw_illegal(input logic [2:0] bhw);
        return !(bhw inside {BHW_B, BHW_H, BHW_W, BHW_BU, BHW_HU});
    endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Byte-lane steering: write byte-enables and replicated write data, plus read lane
// extraction with sign/zero extension. Purely combinational.
module bus_lane_align
    import bus_mem_pkg::*;
(
    input  logic [2:0]  bhw_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    // Write sizes ignore bhw[2], so BU/HU writes behave as B/H; H and W align down.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        case (bhw_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            2'b10:   be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    assign rbyte = rword_i[{lane_i, 3'b000} +: 8];
    assign rhalf = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        rdata_o = '0;
        case (bhw_i)
            BHW_B:   rdata_o = {{24{rbyte[7]}}, rbyte};
            BHW_BU:  rdata_o = {24'h0, rbyte};
            BHW_H:   rdata_o = {{16{rhalf[15]}}, rhalf};
            BHW_HU:  rdata_o = {16'h0, rhalf};
            BHW_W:   rdata_o = rword_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/bus_memory_ws.sv
// Wait-state memory slave: one request at a time, response LATENCY cycles later.
// Optional address/alignment fault checking is enabled by defining BUS_MEM_FAULT_CHECK_EN.
module bus_memory_ws
    import bus_mem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_bus_data,
    input  logic [31:0] i_bus_address,
    input  logic        i_bus_DV,
    input  logic [2:0]  i_bhw,
    input  logic        i_write_notread,
    output logic [31:0] o_bus_data,
    output logic        o_bus_DV,
    output logic        o_busy,
    output logic        o_fault
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

    state_e                 state_q, state_d;
    logic [LAT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            addr_q, data_q;
    logic [2:0]             bhw_q;
    logic                   wnr_q;
    logic                   dv_q, fault_q;
    logic [31:0]            rdata_q;

    logic [31:0]            mem [2**DEPTH_LOG2];
    logic [31:0]            offset;
    logic [DEPTH_LOG2-1:0]  idx;
    logic [31:0]            rword, wdata_al, rdata_ext;
    logic [3:0]             be;
    logic                   fault, mem_we, resp;

    assign offset = addr_q - BASE_ADDR;
    assign idx    = offset[DEPTH_LOG2+1:2];
    assign rword  = mem[idx];
    assign resp   = (state_q == ST_RESP);

    bus_lane_align u_align (
        .bhw_i   (bhw_q),
        .lane_i  (offset[1:0]),
        .wdata_i (data_q),
        .rword_i (rword),
        .be_o    (be),
        .wdata_o (wdata_al),
        .rdata_o (rdata_ext)
    );

`ifdef BUS_MEM_FAULT_CHECK_EN
    logic misaligned, out_of_range;
    assign misaligned   = (bhw_q[1:0] == 2'b01 && offset[0]) ||
                          (bhw_q[1:0] == 2'b10 && offset[1:0] != 2'b00);
    // Addresses below BASE_ADDR wrap to huge offsets and land here too.
    assign out_of_range = (offset >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign fault        = bhw_illegal(bhw_q) || misaligned || out_of_range;
`else
    logic unused_offset_hi;
    assign unused_offset_hi = ^offset[31:DEPTH_LOG2+2];
    assign fault            = bhw_illegal(bhw_q);
`endif

    assign mem_we = resp && wnr_q && !fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (i_bus_DV) begin
                cnt_d   = LAT_LOAD;
                state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LAT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            bhw_q   <= '0;
            wnr_q   <= 1'b0;
            dv_q    <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && i_bus_DV) begin
                addr_q <= i_bus_address;
                data_q <= i_bus_data;
                bhw_q  <= i_bhw;
                wnr_q  <= i_write_notread;
            end
            dv_q    <= resp;
            fault_q <= resp && fault;
            rdata_q <= (resp && !wnr_q && !fault) ? rdata_ext : 32'h0;
        end
    end

    // NOTE: the array has no reset; only control state is reset, so an abandoned write never commits.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && be[b]) mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
        end
    end

    assign o_bus_DV   = dv_q;
    assign o_bus_data = rdata_q;
    assign o_fault    = fault_q;
    assign o_busy     = (state_q != ST_IDLE) || dv_q;

endmodule

// File: tb/tb_bus_memory_ws.sv
// Self-checking bench for bus_memory_ws: directed table, corner sequences, random accesses vs. a byte-array model.
module tb_bus_memory_ws;

    localparam int          DEPTH_LOG2 = 4;
    localparam int          NBYTES     = 4 * (2**DEPTH_LOG2);
    localparam logic [31:0] BASE       = 32'h1000_0000;
    localparam int          LAT        = 3;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_bus_data = '0;
    logic [31:0] i_bus_address = '0;
    logic        i_bus_DV = 1'b0;
    logic [2:0]  i_bhw = '0;
    logic        i_write_notread = 1'b0;
    logic [31:0] o_bus_data;
    logic        o_bus_DV, o_busy, o_fault;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] mem_m [NBYTES];

    bus_memory_ws #(.DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bus_data(i_bus_data),
        .i_bus_address(i_bus_address), .i_bus_DV(i_bus_DV), .i_bhw(i_bhw),
        .i_write_notread(i_write_notread), .o_bus_data(o_bus_data),
        .o_bus_DV(o_bus_DV), .o_busy(o_busy), .o_fault(o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: byte-addressed memory, rules applied directly from size/sign codes.
    task automatic model(input logic wr, input logic [2:0] bhw, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] exp_d, output logic exp_f);
        logic [31:0] off, v;
        int size, start;
        off   = addr - BASE;
        exp_d = 32'h0;
        exp_f = (bhw == 3'b011 || bhw == 3'b110 || bhw == 3'b111);
        size  = (bhw[1:0] == 2'b00) ? 1 : (bhw[1:0] == 2'b01) ? 2 : 4;
`ifdef BUS_MEM_FAULT_CHECK_EN
        if (!exp_f && (off % size) != 0) exp_f = 1'b1;
        if (off >= NBYTES) exp_f = 1'b1;
`endif
        start = int'((off / 4) % (NBYTES / 4)) * 4 + (int'(off % 4) / size) * size;
        if (exp_f) return;
        if (wr) begin
            for (int i = 0; i < size; i++) mem_m[start + i] = data[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[start + i];
            if (size == 1)      exp_d = bhw[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            else if (size == 2) exp_d = bhw[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else                exp_d = v;
        end
    endtask

    // Entered at a falling edge; returns at the falling edge of the response cycle.
    task automatic access(input logic wr, input logic [2:0] bhw, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] rd, output logic f,
                          output int lat, output logic got);
        i_bus_DV = 1'b1; i_write_notread = wr; i_bhw = bhw;
        i_bus_address = addr; i_bus_data = data;
        @(posedge i_clk); #1;
        i_bus_DV = 1'b0; i_bus_data = $urandom; i_bus_address = $urandom;
        got = 1'b0; lat = 0; rd = '0; f = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge i_clk);
            if (o_bus_DV) begin
                got = 1'b1; lat = n - 1; rd = o_bus_data; f = o_fault;
            end
        end
    endtask

    task automatic run_vec(input string name, input logic wr, input logic [2:0] bhw,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_d, input logic exp_f);
        logic [31:0] rd; logic f, got; int lat;
        access(wr, bhw, addr, data, rd, f, lat, got);
        check({name, "_resp"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "_lat"}, 32'(lat), 32'(LAT));
            check({name, "_data"}, rd, exp_d);
            check({name, "_fault"}, 32'(f), 32'(exp_f));
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  bhw;
        logic [31:0] off;
        logic [31:0] data;
        logic [31:0] exp_d;
        logic        exp_f;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] ed, rd0;
        logic ef;
        int resp_cnt;

        vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 32'h11, 32'h0000_0080, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 32'h11, 32'h0,         32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{1'b0, 3'b100, 32'h11, 32'h0,         32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_80EF, 1'b0};
        vecs[6]  = '{1'b1, 3'b001, 32'h12, 32'h0000_1234, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 32'h12, 32'h0,         32'h0000_1234, 1'b0};
        vecs[8]  = '{1'b0, 3'b001, 32'h12, 32'h0,         32'h0000_1234, 1'b0};
        vecs[9]  = '{1'b0, 3'b010, 32'h10, 32'h0,         32'h1234_80EF, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 32'h10, 32'h0,         32'h0, 1'b1};
        vecs[11] = '{1'b1, 3'b010, 32'h00, 32'hCAFE_F00D, 32'h0, 1'b0};
`ifdef BUS_MEM_FAULT_CHECK_EN
        vecs[12] = '{1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1};
`else
        vecs[12] = '{1'b0, 3'b010, 32'h02, 32'h0, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0};
`endif

        repeat (3) @(negedge i_clk);
        check("rst_dv", 32'(o_bus_DV), 32'd0);
        check("rst_data", o_bus_data, 32'h0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_fault", 32'(o_fault), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int w = 0; w < NBYTES / 4; w++) begin
            logic [31:0] d;
            d = $urandom;
            model(1'b1, 3'b010, BASE + 32'(4 * w), d, ed, ef);
            run_vec($sformatf("init%0d", w), 1'b1, 3'b010, BASE + 32'(4 * w), d, ed, ef);
        end

        for (int i = 0; i < 14; i++) begin
            model(vecs[i].wr, vecs[i].bhw, BASE + vecs[i].off, vecs[i].data, ed, ef);
            run_vec($sformatf("tbl%0d", i), vecs[i].wr, vecs[i].bhw, BASE + vecs[i].off,
                    vecs[i].data, vecs[i].exp_d, vecs[i].exp_f);
        end

        // Outputs return to zero after the response cycle.
        @(negedge i_clk);
        check("idle_dv", 32'(o_bus_DV), 32'd0);
        check("idle_data", o_bus_data, 32'h0);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Second request while busy must be dropped.
        model(1'b0, 3'b010, BASE + 32'h10, 32'h0, rd0, ef);
        i_bus_DV = 1'b1; i_write_notread = 1'b0; i_bhw = 3'b010; i_bus_address = BASE + 32'h10;
        @(posedge i_clk); #1;
        i_bus_DV = 1'b0;
        check("busy_after_accept", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        i_bus_DV = 1'b1; i_write_notread = 1'b1; i_bhw = 3'b010;
        i_bus_address = BASE + 32'h20; i_bus_data = 32'h0BAD_BEEF;
        @(posedge i_clk); #1;
        i_bus_DV = 1'b0;
        resp_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge i_clk);
            if (o_bus_DV) begin
                resp_cnt++;
                check("drop_first_data", o_bus_data, rd0);
            end
        end
        check("drop_resp_count", 32'(resp_cnt), 32'd1);
        model(1'b0, 3'b010, BASE + 32'h20, 32'h0, ed, ef);
        run_vec("drop_readback", 1'b0, 3'b010, BASE + 32'h20, 32'h0, ed, ef);

        // Reset during WAIT of a write: no response, no commit.
        i_bus_DV = 1'b1; i_write_notread = 1'b1; i_bhw = 3'b010;
        i_bus_address = BASE + 32'h24; i_bus_data = 32'h55AA_55AA;
        @(posedge i_clk); #1;
        i_bus_DV = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        resp_cnt = 0;
        for (int n = 0; n < LAT + 4; n++) begin
            @(negedge i_clk);
            if (o_bus_DV) resp_cnt++;
        end
        check("midrst_no_resp", 32'(resp_cnt), 32'd0);
        model(1'b0, 3'b010, BASE + 32'h24, 32'h0, ed, ef);
        run_vec("midrst_readback", 1'b0, 3'b010, BASE + 32'h24, 32'h0, ed, ef);

        // Random accesses, back to back, against the model.
        for (int i = 0; i < 60; i++) begin
            logic        wr;
            logic [2:0]  bhw;
            logic [31:0] addr, d;
            wr   = 1'($urandom_range(0, 1));
            bhw  = 3'($urandom_range(0, 7));
            addr = BASE + 32'($urandom_range(0, NBYTES + 15));
            d    = $urandom;
            model(wr, bhw, addr, d, ed, ef);
            run_vec($sformatf("rnd%0d", i), wr, bhw, addr, d, ed, ef);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
